// File: rtl/hawk_axird_arb.sv
// Two-master AXI read arbiter: m0 (Hawk) has fixed priority with a starvation
// guard for m1 (CPU stall path); R beats are steered by an in-order route FIFO.
`timescale 1ns/1ps
module hawk_axird_arb #(
  parameter int ID_W   = 6,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int OUTST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   m0_arid,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  input  logic [2:0]        m0_arprot,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ID_W-1:0]   m1_arid,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  input  logic [2:0]        m1_arprot,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [ID_W-1:0]   m0_rid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [ID_W-1:0]   m1_rid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ID_W-1:0]   out_arid,
  output logic [ADDR_W-1:0] out_araddr,
  output logic [7:0]        out_arlen,
  output logic [2:0]        out_arsize,
  output logic [1:0]        out_arburst,
  output logic [2:0]        out_arprot,
  output logic              out_arvalid,
  input  logic              out_arready,
  input  logic [ID_W-1:0]   out_rid,
  input  logic [DATA_W-1:0] out_rdata,
  input  logic [1:0]        out_rresp,
  input  logic              out_rlast,
  input  logic              out_rvalid,
  output logic              out_rready
);

  localparam int PW = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam int CW = $clog2(OUTST + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTST);

  logic [2:0]       starve_q, starve_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [OUTST-1:0] route_q;
  logic             win1, full, empty, load, pop, head;

  always_comb begin
    win1       = m1_arvalid & (!m0_arvalid | (starve_q == 3'd3));
    full       = (count_q == FULL_CNT);
    empty      = (count_q == '0);
    // rst gates load so no arready is offered while the block is held in reset
    load       = (!out_arvalid | out_arready) & !full & (m0_arvalid | m1_arvalid) & !rst;
    m0_arready = load & !win1;
    m1_arready = load & win1;
    head       = route_q[rd_ptr_q];
    out_rready = !empty & (head ? m1_rready : m0_rready);
    m0_rvalid  = !empty & !head & out_rvalid;
    m1_rvalid  = !empty & head & out_rvalid;
    pop        = out_rvalid & out_rready & out_rlast;
  end

  always_comb begin
    starve_d = starve_q;
    if (!m1_arvalid)
      starve_d = '0;
    else if (load)
      starve_d = win1 ? 3'd0 : starve_q + 3'd1;
  end

  assign m0_rid   = out_rid;
  assign m0_rdata = out_rdata;
  assign m0_rresp = out_rresp;
  assign m0_rlast = out_rlast;
  assign m1_rid   = out_rid;
  assign m1_rdata = out_rdata;
  assign m1_rresp = out_rresp;
  assign m1_rlast = out_rlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_arvalid <= 1'b0;
      out_arid    <= '0;
      out_araddr  <= '0;
      out_arlen   <= '0;
      out_arsize  <= '0;
      out_arburst <= '0;
      out_arprot  <= '0;
    end else if (load) begin
      out_arvalid <= 1'b1;
      out_arid    <= win1 ? m1_arid    : m0_arid;
      out_araddr  <= win1 ? m1_araddr  : m0_araddr;
      out_arlen   <= win1 ? m1_arlen   : m0_arlen;
      out_arsize  <= win1 ? m1_arsize  : m0_arsize;
      out_arburst <= win1 ? m1_arburst : m0_arburst;
      out_arprot  <= win1 ? m1_arprot  : m0_arprot;
    end else if (out_arready) begin
      out_arvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      route_q  <= '0;
    end else begin
      starve_q <= starve_d;
      if (load) begin
        route_q[wr_ptr_q] <= win1;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({load, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_hawk_axird_arb.sv
// Directed bench for hawk_axird_arb: a per-cycle vector table for arbitration
// and routing, then hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_hawk_axird_arb;

  localparam int ID_W   = 6;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 512;
  localparam int OUTST  = 4;

  logic clk, rst;
  logic [ID_W-1:0]   m0_arid, m1_arid, m0_rid, m1_rid, out_arid, out_rid;
  logic [ADDR_W-1:0] m0_araddr, m1_araddr, out_araddr;
  logic [7:0]        m0_arlen, m1_arlen, out_arlen;
  logic [2:0]        m0_arsize, m1_arsize, out_arsize, m0_arprot, m1_arprot, out_arprot;
  logic [1:0]        m0_arburst, m1_arburst, out_arburst;
  logic              m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [DATA_W-1:0] m0_rdata, m1_rdata, out_rdata;
  logic [1:0]        m0_rresp, m1_rresp, out_rresp;
  logic              m0_rlast, m1_rlast, out_rlast;
  logic              m0_rvalid, m1_rvalid, out_rvalid;
  logic              m0_rready, m1_rready, out_rready;
  logic              out_arvalid, out_arready;

  int n_vec = 0;
  int n_err = 0;
  int n_hs;

  hawk_axird_arb #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUTST(OUTST)) dut (
    .clk(clk), .rst(rst),
    .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arprot(m0_arprot), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arprot(m1_arprot), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .out_arid(out_arid), .out_araddr(out_araddr), .out_arlen(out_arlen), .out_arsize(out_arsize),
    .out_arburst(out_arburst), .out_arprot(out_arprot), .out_arvalid(out_arvalid),
    .out_arready(out_arready),
    .out_rid(out_rid), .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rlast(out_rlast),
    .out_rvalid(out_rvalid), .out_rready(out_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct packed {
    logic        m0v, m1v;
    logic        ar0, ar1, av;
    logic [15:0] addr;
    logic        rv0, rv1, rr;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_arid = 6'h01; m1_arid = 6'h02;
    m0_araddr = '0;  m1_araddr = '0;
    m0_arlen = '0;   m1_arlen = '0;
    m0_arsize = 3'd6; m1_arsize = 3'd6;
    m0_arburst = 2'b01; m1_arburst = 2'b01;
    m0_arprot = '0;  m1_arprot = '0;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    m0_rready = 1'b0; m1_rready = 1'b0;
    out_arready = 1'b0;
    out_rid = '0; out_rdata = '0; out_rresp = '0; out_rlast = 1'b0; out_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    //               m0v   m1v   ar0   ar1   av    addr      rv0   rv1   rr
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1001, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1002, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h2003, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1004, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1005, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1006, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h2007, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1008, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1009, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h100A, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h100B, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h100C, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h200D, 1'b0, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h200D, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    idle();
    do_reset();

    // Arbitration table: both masters streaming, MC always ready and returning
    // single-beat bursts so each cycle pops the previous grant.
    chk("reset_upper_addr", 64'(out_araddr[63:16]), 64'd0);
    out_arready = 1'b1; out_rvalid = 1'b1; out_rlast = 1'b1;
    m0_rready = 1'b1; m1_rready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      m0_arvalid = tbl[i].m0v;
      m1_arvalid = tbl[i].m1v;
      m0_araddr  = 64'h1000 + 64'(i);
      m1_araddr  = 64'h2000 + 64'(i);
      mid();
      chk($sformatf("table_row%0d", i),
          64'({m0_arready, m1_arready, out_arvalid, out_araddr[15:0], m0_rvalid, m1_rvalid, out_rready}),
          64'({tbl[i].ar0, tbl[i].ar1, tbl[i].av, tbl[i].addr, tbl[i].rv0, tbl[i].rv1, tbl[i].rr}));
      nxt();
    end

    // Route FIFO fills at four outstanding bursts; non-last beats do not pop.
    do_reset();
    m0_arvalid = 1'b1; m0_araddr = 64'h4000; m0_arlen = 8'd1;
    out_arready = 1'b1; m0_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mid(); chk("fill_arready", 64'(m0_arready), 64'd1); nxt();
    end
    for (int k = 0; k < 3; k++) begin
      mid(); chk("full_block", 64'({m0_arready, out_rready}), 64'b01); nxt();
    end
    out_rvalid = 1'b1; out_rlast = 1'b0;
    mid(); chk("nonlast_nopop", 64'({m0_arready, m0_rvalid, out_rready}), 64'b011); nxt();
    out_rlast = 1'b1;
    mid(); chk("last_beat_still_full", 64'({m0_arready, m0_rvalid, out_rready}), 64'b011); nxt();
    out_rvalid = 1'b0; out_rlast = 1'b0;
    mid(); chk("after_pop_arready", 64'(m0_arready), 64'd1); nxt();
    m0_arvalid = 1'b0;

    // m1 then m0 outstanding; beats routed in order.
    do_reset();
    out_arready = 1'b1;
    m1_arvalid = 1'b1; m1_araddr = 64'h5000;
    mid(); chk("order_m1_grant", 64'({m0_arready, m1_arready}), 64'b01); nxt();
    m1_arvalid = 1'b0; m0_arvalid = 1'b1; m0_araddr = 64'h6000;
    mid(); chk("order_m0_grant", 64'({m0_arready, m1_arready}), 64'b10); nxt();
    m0_arvalid = 1'b0;
    m0_rready = 1'b1; m1_rready = 1'b1;
    out_rvalid = 1'b1; out_rlast = 1'b1; out_rid = 6'h15;
    out_rdata = '0; out_rdata[7:0] = 8'h0A;
    mid();
    chk("route_A_valid", 64'({m0_rvalid, m1_rvalid}), 64'b01);
    chk("route_A_data", 64'({m1_rid, m1_rdata[7:0]}), 64'h150A);
    nxt();
    out_rdata[7:0] = 8'h0B;
    mid();
    chk("route_B_valid", 64'({m0_rvalid, m1_rvalid}), 64'b10);
    chk("route_B_data", 64'({m0_rid, m0_rdata[7:0]}), 64'h150B);
    nxt();
    mid(); chk("empty_holdoff", 64'({m0_rvalid, m1_rvalid, out_rready}), 64'b000); nxt();
    out_rvalid = 1'b0; out_rlast = 1'b0;

    // MC stalls AR for five cycles; the held request must not change or repeat.
    do_reset();
    m1_arvalid = 1'b1; m1_araddr = 64'h3000;
    mid(); chk("stall_first_load", 64'(m1_arready), 64'd1); nxt();
    m1_araddr = 64'h3100;
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("stall_hold", 64'({out_arvalid, m1_arready, out_araddr[15:0]}), 64'({1'b1, 1'b0, 16'h3000}));
      nxt();
    end
    out_arready = 1'b1; n_hs = 0;
    mid();
    chk("ready_rise_load", 64'(m1_arready), 64'd1);
    if (out_arvalid && out_arready && out_araddr == 64'h3000) n_hs++;
    nxt();
    m1_arvalid = 1'b0;
    mid();
    chk("next_ar", 64'({out_arvalid, out_araddr[15:0]}), 64'({1'b1, 16'h3100}));
    if (out_arvalid && out_arready && out_araddr == 64'h3000) n_hs++;
    nxt();
    for (int k = 0; k < 2; k++) begin
      mid();
      if (out_arvalid && out_arready && out_araddr == 64'h3000) n_hs++;
      nxt();
    end
    chk("single_issue", 64'(n_hs), 64'd1);

    // Head master withholds rready: no pop until it accepts.
    do_reset();
    out_arready = 1'b1;
    m0_arvalid = 1'b1; m0_araddr = 64'h7000;
    nxt();
    m0_arvalid = 1'b0;
    out_rvalid = 1'b1; out_rlast = 1'b1;
    out_rdata = '0; out_rdata[7:0] = 8'h55;
    for (int k = 0; k < 3; k++) begin
      mid(); chk("rready_stall", 64'({out_rready, m0_rvalid, m1_rvalid}), 64'b010); nxt();
    end
    m0_rready = 1'b1;
    mid();
    chk("rready_resume", 64'({out_rready, m0_rvalid, m0_rdata[7:0]}), 64'({2'b11, 8'h55}));
    nxt();
    mid(); chk("rready_popped", 64'({out_rready, m0_rvalid}), 64'b00); nxt();
    out_rvalid = 1'b0;

    // Asynchronous reset mid-burst with two outstanding, then a fresh read.
    do_reset();
    out_arready = 1'b1;
    m0_arvalid = 1'b1; m0_araddr = 64'h8000;
    nxt();
    m0_arvalid = 1'b0; m1_arvalid = 1'b1; m1_araddr = 64'h9000;
    nxt();
    m1_arvalid = 1'b0; m0_arvalid = 1'b1;
    out_rvalid = 1'b1; out_rlast = 1'b0; m0_rready = 1'b1; m1_rready = 1'b1;
    mid();
    chk("pre_reset", 64'({out_arvalid, m0_arready, m0_rvalid, out_araddr[15:0]}), 64'({3'b111, 16'h9000}));
    #1 rst = 1'b1;
    #1;
    chk("async_reset_outputs",
        64'({out_arvalid, out_araddr[15:0], out_arid, m0_arready, m1_arready, m0_rvalid, m1_rvalid, out_rready}),
        64'd0);
    out_rvalid = 1'b0;
    m0_araddr = 64'h1000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mid(); chk("post_reset_load", 64'(m0_arready), 64'd1); nxt();
    m0_arvalid = 1'b0;
    mid(); chk("post_reset_ar", 64'({out_arvalid, out_araddr[15:0]}), 64'({1'b1, 16'h1000})); nxt();
    out_rvalid = 1'b1; out_rlast = 1'b1;
    out_rdata = '0; out_rdata[7:0] = 8'h0C;
    mid();
    chk("post_reset_route", 64'({m0_rvalid, m1_rvalid, out_rready, m0_rdata[7:0]}), 64'({3'b101, 8'h0C}));
    nxt();
    mid(); chk("post_reset_empty", 64'({m0_rvalid, m1_rvalid, out_rready}), 64'b000); nxt();
    out_rvalid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
